// File: rtl/ex_result_stage.sv
// Result pipeline register behind the execute ALU: sign-extends word ops, masks x0 writes,
// and buffers two entries so in_ready stays registered. EX_RESULT_FWD_EN enables the forwarding port.
module ex_result_stage #(
  parameter int n  = 64,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [n-1:0]  alu_result,
  input  logic          is_word,
  input  logic [RA-1:0] rd_addr,
  input  logic          rd_we,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  out_result,
  output logic [RA-1:0] out_rd_addr,
  output logic          out_rd_we,
  output logic          fwd_valid,
  output logic [RA-1:0] fwd_addr,
  output logic [n-1:0]  fwd_data
);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and in_ready comes straight from a flop.

  // State bit 0 is main.valid, bit 1 is skid.valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t        state, state_next;
  logic          in_ready_q;
  logic          accept, emit;
  logic          load_main_in, load_main_skid, load_skid;
  logic [n-1:0]  formed_result;
  logic          formed_we;
  logic [n-1:0]  main_result, skid_result;
  logic [RA-1:0] main_rd, skid_rd;
  logic          main_we, skid_we;

  assign formed_result = is_word ? {{(n-32){alu_result[31]}}, alu_result[31:0]} : alu_result;
  assign formed_we     = rd_we & (rd_addr != '0);
  assign in_ready      = in_ready_q;
  assign accept        = in_valid & in_ready_q;
  assign emit          = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != TWO);
    end
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_next   = ONE;
        load_main_in = 1'b1;
      end
      ONE: begin
        if (accept && emit) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (emit) begin
          state_next = EMPTY;
        end
      end
      TWO: if (emit) begin
        state_next     = ONE;
        load_main_skid = 1'b1;
      end
      default: state_next = EMPTY;
    endcase
    // Flush wins over any accept/emit; payload loads are harmless once valid is cleared.
    if (flush) state_next = EMPTY;
  end

  always_comb begin
    out_valid   = state[0];
    out_result  = main_result;
    out_rd_addr = main_rd;
    out_rd_we   = main_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_result <= '0;
      main_rd     <= '0;
      main_we     <= 1'b0;
      skid_result <= '0;
      skid_rd     <= '0;
      skid_we     <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_result <= formed_result;
        main_rd     <= rd_addr;
        main_we     <= formed_we;
      end else if (load_main_skid) begin
        main_result <= skid_result;
        main_rd     <= skid_rd;
        main_we     <= skid_we;
      end
      if (load_skid) begin
        skid_result <= formed_result;
        skid_rd     <= rd_addr;
        skid_we     <= formed_we;
      end
    end
  end

`ifdef EX_RESULT_FWD_EN
  assign fwd_valid = out_valid & out_rd_we;
  assign fwd_addr  = out_rd_addr;
  assign fwd_data  = out_result;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// Self-checking bench for ex_result_stage: directed scenarios plus a random stream,
// with a queue model of the two-entry buffer tracking every transfer.
module tb_ex_result_stage;

  localparam int EW = 70;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, is_word, rd_we, flush;
  logic        out_valid, out_ready, out_rd_we, fwd_valid;
  logic [63:0] alu_result, out_result, fwd_data;
  logic [4:0]  rd_addr, out_rd_addr, fwd_addr;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  ex_result_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .is_word(is_word), .rd_addr(rd_addr), .rd_we(rd_we),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic w, input logic [63:0] a,
                                       input logic [4:0] rd, input logic we);
    logic [63:0] r;
    r = w ? {{32{a[31]}}, a[31:0]} : a;
    return {r, rd, we && (rd != 5'd0)};
  endfunction

  // Scoreboard: queue occupancy mirrors the buffer; head is what the outputs must show.
  always @(negedge clk) begin
    int occ;
    logic [EW-1:0] head;
    if (rst) begin
      exp_q.delete();
    end else begin
      occ = exp_q.size();
      check("occ_out_valid", out_valid, occ > 0);
      check("occ_in_ready", in_ready, occ < 2);
      if (occ > 0) begin
        head = exp_q[0];
        check("sb_result", out_result, head[69:6]);
        check("sb_rd_addr", out_rd_addr, head[5:1]);
        check("sb_rd_we", out_rd_we, head[0]);
`ifdef EX_RESULT_FWD_EN
        check("sb_fwd_valid", fwd_valid, head[0]);
        if (head[0]) begin
          check("sb_fwd_addr", fwd_addr, head[5:1]);
          check("sb_fwd_data", fwd_data, head[69:6]);
        end
`endif
        if (out_ready) void'(exp_q.pop_front());
      end else begin
`ifdef EX_RESULT_FWD_EN
        check("sb_fwd_valid", fwd_valid, 1'b0);
`endif
      end
`ifndef EX_RESULT_FWD_EN
      check("sb_fwd_off", {fwd_valid, fwd_addr, fwd_data[57:0]}, 64'd0);
`endif
      if (flush) exp_q.delete();
      else if (in_valid && occ < 2) exp_q.push_back(mk(is_word, alu_result, rd_addr, rd_we));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [63:0] a, input logic [4:0] rd, input logic we);
    in_valid   = 1'b1;
    is_word    = w;
    alu_result = a;
    rd_addr    = rd;
    rd_we      = we;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; is_word = 1'b0; alu_result = '0; rd_addr = '0;
    rd_we = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_rd", {out_rd_addr, out_rd_we}, 64'd0);
    check("rst_fwd", {fwd_valid, fwd_addr, fwd_data[57:0]}, 64'd0);

    // Word sign-extension and pass-through
    tick(); out_ready = 1'b1; drive(1'b1, 64'h0000_0000_8000_0001, 5'd5, 1'b1);
    tick(); idle();
    @(negedge clk);
    check("word_valid", out_valid, 1'b1);
    check("word_result", out_result, 64'hFFFF_FFFF_8000_0001);
    check("word_we", out_rd_we, 1'b1);
    tick(); drive(1'b0, 64'h0000_0000_8000_0001, 5'd5, 1'b1);
    tick(); idle();
    @(negedge clk);
    check("dword_result", out_result, 64'h0000_0000_8000_0001);

    // x0 suppression
    tick(); drive(1'b0, 64'h1234, 5'd0, 1'b1);
    tick(); idle();
    @(negedge clk);
    check("x0_valid", out_valid, 1'b1);
    check("x0_we", out_rd_we, 1'b0);
    check("x0_fwd", fwd_valid, 1'b0);

    // Back-pressure: A, B fill the buffer, C is held off
    tick(); out_ready = 1'b0; drive(1'b0, 64'hA, 5'd1, 1'b1);
    tick(); drive(1'b0, 64'hB, 5'd2, 1'b1);
    tick(); drive(1'b0, 64'hC, 5'd3, 1'b1);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_head_a", out_result, 64'hA);
    tick();
    @(negedge clk);
    check("bp_still_full", in_ready, 1'b0);
    check("bp_stable_a", out_result, 64'hA);
    tick(); out_ready = 1'b1;
    @(negedge clk);
    check("bp_emit_a", out_result, 64'hA);
    tick();
    @(negedge clk);
    check("bp_emit_b", out_result, 64'hB);
    check("bp_in_ready_back", in_ready, 1'b1);
    tick(); idle();
    @(negedge clk);
    check("bp_emit_c", out_result, 64'hC);
    tick();
    @(negedge clk);
    check("bp_drained", out_valid, 1'b0);

    // Flush in TWO with D offered
    tick(); out_ready = 1'b0; drive(1'b0, 64'h11, 5'd4, 1'b1);
    tick(); drive(1'b0, 64'h22, 5'd4, 1'b1);
    tick(); drive(1'b0, 64'hDD, 5'd6, 1'b1); flush = 1'b1;
    tick(); flush = 1'b0; idle();
    @(negedge clk);
    check("flush2_valid", out_valid, 1'b0);
    check("flush2_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("flush2_no_d", out_valid, 1'b0);
    end

    // Flush in ONE with E offered while in_ready is high
    tick(); out_ready = 1'b0; drive(1'b0, 64'h33, 5'd8, 1'b1);
    tick(); drive(1'b0, 64'hEE, 5'd9, 1'b1); flush = 1'b1;
    tick(); flush = 1'b0; idle();
    @(negedge clk);
    check("flush1_valid", out_valid, 1'b0);
    check("flush1_in_ready", in_ready, 1'b1);

    // Reset while in ONE, then normal latency
    tick(); drive(1'b1, 64'h5555_5555_F000_0000, 5'd3, 1'b1);
    tick(); idle();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_in_ready", in_ready, 1'b1);
    check("mrst_result", out_result, 64'd0);
    check("mrst_rd", {out_rd_addr, out_rd_we}, 64'd0);
    check("mrst_fwd", {fwd_valid, fwd_addr, fwd_data[57:0]}, 64'd0);
    tick(); drive(1'b0, 64'h77, 5'd10, 1'b1);
    tick(); idle();
    @(negedge clk);
    check("mrst_latency", out_valid, 1'b1);
    check("mrst_result2", out_result, 64'h77);
    tick(); out_ready = 1'b1;
    tick();

    // Forwarding from a stalled head entry
    out_ready = 1'b0; drive(1'b0, 64'h42, 5'd7, 1'b1);
    tick(); idle();
    @(negedge clk);
`ifdef EX_RESULT_FWD_EN
    check("fwd_valid", fwd_valid, 1'b1);
    check("fwd_addr", fwd_addr, 5'd7);
    check("fwd_data", fwd_data, 64'h42);
`else
    check("fwd_valid", fwd_valid, 1'b0);
    check("fwd_addr", fwd_addr, 5'd0);
    check("fwd_data", fwd_data, 64'd0);
`endif
    tick(); out_ready = 1'b1;
    tick();

    // Random stream
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      is_word    = $urandom_range(0, 1) == 1;
      alu_result = {$urandom, $urandom};
      rd_addr    = 5'($urandom_range(0, 31));
      rd_we      = $urandom_range(0, 3) != 0;
      out_ready  = $urandom_range(0, 2) != 0;
      flush      = $urandom_range(0, 24) == 0;
      tick();
    end
    idle(); flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("final_empty", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
